// File: rtl/goe_if.sv
// goe_if: bundles the packet-in, PHV, packet-out and configuration-chain
// signals of the packet output engine. The slave modport is the engine's view;
// the master modport is the surrounding pipeline's view.
interface goe_if;
  logic [133:0]  in_goe_data;
  logic          in_goe_data_wr;
  logic          in_goe_valid_wr;
  logic          in_goe_valid;
  logic          out_goe_alf;
  logic [1023:0] in_goe_phv;
  logic          in_goe_phv_wr;
  logic          out_goe_phv_alf;
  logic [133:0]  pktout_data;
  logic          pktout_data_wr;
  logic          pktout_data_valid;
  logic          pktout_data_valid_wr;
  logic          in_pktout_alf;
  logic [133:0]  cin_goe_data;
  logic          cin_goe_data_wr;
  logic          cout_goe_ready;
  logic [133:0]  cout_goe_data;
  logic          cout_goe_data_wr;
  logic          cin_goe_ready;

  modport slave (
    input  in_goe_data, in_goe_data_wr, in_goe_valid_wr, in_goe_valid,
    input  in_goe_phv, in_goe_phv_wr, in_pktout_alf,
    input  cin_goe_data, cin_goe_data_wr, cin_goe_ready,
    output out_goe_alf, out_goe_phv_alf,
    output pktout_data, pktout_data_wr, pktout_data_valid, pktout_data_valid_wr,
    output cout_goe_ready, cout_goe_data, cout_goe_data_wr
  );

  modport master (
    output in_goe_data, in_goe_data_wr, in_goe_valid_wr, in_goe_valid,
    output in_goe_phv, in_goe_phv_wr, in_pktout_alf,
    output cin_goe_data, cin_goe_data_wr, cin_goe_ready,
    input  out_goe_alf, out_goe_phv_alf,
    input  pktout_data, pktout_data_wr, pktout_data_valid, pktout_data_valid_wr,
    input  cout_goe_ready, cout_goe_data, cout_goe_data_wr
  );
endinterface

// File: rtl/goe.sv
// goe: packet output engine. Buffers packet words, pairs each packet in order
// with its keep flag and PHV drop bit, then forwards it on pktout or drains it.
// The configuration chain passes through a single register stage.
// Optional macro GOE_STAT_EN adds forwarded/dropped/overflow counters.
module goe #(
  parameter int DROP_BIT   = 1020,
  parameter int ALF_THRESH = 192,
  parameter int PHV_ALF    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  goe_if.slave        bus
`ifdef GOE_STAT_EN
  ,
  output logic [31:0] out_goe_fwd_cnt,
  output logic [31:0] out_goe_drop_cnt,
  output logic [15:0] out_goe_ovf_cnt
`endif
);

  localparam logic [8:0] D_ALF = 9'(ALF_THRESH);
  localparam logic [5:0] V_ALF = 6'd28;
  localparam logic [4:0] P_ALF = 5'(PHV_ALF);
  localparam logic [1:0] FLAG_TAIL = 2'b10;

  typedef enum logic [1:0] {IDLE, SEND, DISCARD} state_t;

  state_t state, state_nxt;

  logic [133:0] d_mem [256];
  logic [8:0]   d_wp, d_rp, d_cnt;
  logic         d_full, d_empty, d_we, d_rd;

  logic [31:0]  v_mem;
  logic [5:0]   v_wp, v_rp, v_cnt;
  logic         v_full, v_empty, v_we, v_head;

  logic [15:0]  p_mem;
  logic [4:0]   p_wp, p_rp, p_cnt;
  logic         p_full, p_empty, p_we, p_head;

  logic         pop, head_is_tail;
  logic [133:0] d_q;
  logic         emit_q;
  logic         tail_out;

  // Pointer distance gives occupancy; the extra MSB distinguishes full from empty.
  assign d_cnt   = d_wp - d_rp;
  assign d_full  = d_cnt[8];
  assign d_empty = (d_cnt == 9'd0);
  assign d_we    = bus.in_goe_data_wr & ~d_full;

  assign v_cnt   = v_wp - v_rp;
  assign v_full  = v_cnt[5];
  assign v_empty = (v_cnt == 6'd0);
  assign v_we    = bus.in_goe_valid_wr & ~v_full;

  assign p_cnt   = p_wp - p_rp;
  assign p_full  = p_cnt[4];
  assign p_empty = (p_cnt == 5'd0);
  assign p_we    = bus.in_goe_phv_wr & ~p_full;

  // Small FIFOs are read show-ahead so IDLE can decide in the same cycle it pops.
  assign v_head       = v_mem[v_rp[4:0]];
  assign p_head       = p_mem[p_rp[3:0]];
  assign head_is_tail = (d_mem[d_rp[7:0]][133:132] == FLAG_TAIL);
  assign tail_out     = emit_q & (d_q[133:132] == FLAG_TAIL);

  // FIFO storage; flushing is done by resetting the pointers, not the arrays.
  always_ff @(posedge clk) begin
    if (d_we) d_mem[d_wp[7:0]] <= bus.in_goe_data;
    if (v_we) v_mem[v_wp[4:0]] <= bus.in_goe_valid;
    if (p_we) p_mem[p_wp[3:0]] <= bus.in_goe_phv[DROP_BIT];
  end

  // FIFO read/write pointers; valid and PHV FIFOs always advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_wp <= '0;
      d_rp <= '0;
      v_wp <= '0;
      v_rp <= '0;
      p_wp <= '0;
      p_rp <= '0;
    end else begin
      if (d_we) d_wp <= d_wp + 9'd1;
      if (d_rd) d_rp <= d_rp + 9'd1;
      if (v_we) v_wp <= v_wp + 6'd1;
      if (p_we) p_wp <= p_wp + 5'd1;
      if (pop) begin
        v_rp <= v_rp + 6'd1;
        p_rp <= p_rp + 5'd1;
      end
    end
  end

  // State register for the forward/discard sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: pick a packet's fate in IDLE, then read words until its tail.
  always_comb begin
    state_nxt = state;
    d_rd      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!v_empty && !p_empty) begin
          if (v_head && !p_head) begin
            if (!bus.in_pktout_alf) begin
              pop       = 1'b1;
              state_nxt = SEND;
            end
          end else begin
            pop       = 1'b1;
            state_nxt = DISCARD;
          end
        end
      end
      SEND: begin
        if (!bus.in_pktout_alf && !d_empty) begin
          d_rd = 1'b1;
          if (head_is_tail) state_nxt = IDLE;
        end
      end
      DISCARD: begin
        if (!d_empty) begin
          d_rd = 1'b1;
          if (head_is_tail) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data FIFO registered read port plus a flag saying the word is to be emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= '0;
      emit_q <= 1'b0;
    end else begin
      emit_q <= d_rd & (state == SEND);
      if (d_rd) d_q <= d_mem[d_rp[7:0]];
    end
  end

  // Registered pktout stage; words already read complete even if downstream fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pktout_data          <= '0;
      bus.pktout_data_wr       <= 1'b0;
      bus.pktout_data_valid    <= 1'b0;
      bus.pktout_data_valid_wr <= 1'b0;
    end else begin
      bus.pktout_data_wr       <= emit_q;
      bus.pktout_data_valid    <= tail_out;
      bus.pktout_data_valid_wr <= tail_out;
      if (emit_q) bus.pktout_data <= d_q;
    end
  end

  // Registered almost-full flags back to the upstream stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_goe_alf     <= 1'b0;
      bus.out_goe_phv_alf <= 1'b0;
    end else begin
      bus.out_goe_alf     <= (d_cnt >= D_ALF) | (v_cnt >= V_ALF);
      bus.out_goe_phv_alf <= (p_cnt >= P_ALF);
    end
  end

  // Configuration chain: one register stage, ready mirrored one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cout_goe_data    <= '0;
      bus.cout_goe_data_wr <= 1'b0;
      bus.cout_goe_ready   <= 1'b1;
    end else begin
      bus.cout_goe_data    <= bus.cin_goe_data;
      bus.cout_goe_data_wr <= bus.cin_goe_data_wr;
      bus.cout_goe_ready   <= bus.cin_goe_ready;
    end
  end

`ifdef GOE_STAT_EN
  logic d_ovf, v_ovf, p_ovf;

  assign d_ovf = bus.in_goe_data_wr  & d_full;
  assign v_ovf = bus.in_goe_valid_wr & v_full;
  assign p_ovf = bus.in_goe_phv_wr   & p_full;

  // Free-running wrap-around statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_goe_fwd_cnt  <= '0;
      out_goe_drop_cnt <= '0;
      out_goe_ovf_cnt  <= '0;
    end else begin
      if (tail_out) out_goe_fwd_cnt <= out_goe_fwd_cnt + 32'd1;
      if (d_rd && (state == DISCARD) && head_is_tail)
        out_goe_drop_cnt <= out_goe_drop_cnt + 32'd1;
      out_goe_ovf_cnt <= out_goe_ovf_cnt + {15'd0, d_ovf} + {15'd0, v_ovf} + {15'd0, p_ovf};
    end
  end
`endif

endmodule
